// File: rtl/ob_mk_cnt_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ob_mk_cnt_ctrl
// Purpose  : Sequencer around the market-table quantity counter. Takes a
//            depth query, fires one counter start pulse, freezes table
//            updates while the count runs, latches the accumulated quantity
//            and returns it with a "target reachable" flag over a
//            valid/accept handshake.
// Options  : OB_MK_CNT_CTRL_TIMEOUT_EN - abort a WAIT that lasts TIMEOUT_N
//            cycles and respond with rsp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module ob_mk_cnt_ctrl #(
  parameter int QTY_W     = 16,
  parameter int ACC_W     = 24
`ifdef OB_MK_CNT_CTRL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_N = 64
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_vld,
  input  logic [QTY_W-1:0] req_quantity,
  output logic             req_rdy,
  output logic             cnt_cmd_vld,
  input  logic             cnt_busy,
  input  logic [ACC_W-1:0] cnt_rsp_quantity,
  output logic             tbl_lock,
  output logic             rsp_vld,
  input  logic             rsp_accept,
  output logic [ACC_W-1:0] rsp_quantity,
  output logic             rsp_ok,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_WAIT  = 2'd2;
  localparam logic [1:0] c_RSP   = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [QTY_W-1:0] r_target;
  logic [ACC_W-1:0] r_rsp_quantity;
  logic             r_rsp_ok;
  logic [ACC_W-1:0] w_target_ext;
  logic             w_cnt_done;
  logic             w_timeout;

  // Target is unsigned, so widening is a plain zero-extension.
  assign w_target_ext = ACC_W'(r_target);
  // Counter reports its final stage as the first non-busy cycle in WAIT.
  assign w_cnt_done   = (r_state == c_WAIT) && !cnt_busy;

`ifdef OB_MK_CNT_CTRL_TIMEOUT_EN
  localparam int               c_CNT_W    = $clog2(TIMEOUT_N + 1);
  localparam logic [c_CNT_W-1:0] c_TMO_LAST = c_CNT_W'(TIMEOUT_N - 1);

  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               r_rsp_err;

  // Count WAIT cycles; cleared in ISSUE so every WAIT starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_ISSUE) begin
      r_wait_cnt <= '0;
    end else if (r_state == c_WAIT && r_wait_cnt != c_TMO_LAST) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Abort on the TIMEOUT_N-th WAIT cycle if the counter is still busy.
  assign w_timeout = (r_state == c_WAIT) && cnt_busy && (r_wait_cnt == c_TMO_LAST);

  // Error flag: cleared by a normal completion, set by an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_err <= 1'b0;
    end else if (w_cnt_done) begin
      r_rsp_err <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_err <= 1'b1;
    end
  end

  assign rsp_err = r_rsp_err;
`else
  assign w_timeout = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (req_vld) w_state_nxt = c_ISSUE;
      c_ISSUE: w_state_nxt = c_WAIT;
      c_WAIT:  if (w_cnt_done || w_timeout) w_state_nxt = c_RSP;
      c_RSP:   if (rsp_accept) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // Outputs are pure state decodes so no request input reaches them combinationally.
  always_comb begin
    req_rdy     = (r_state == c_IDLE);
    cnt_cmd_vld = (r_state == c_ISSUE);
    tbl_lock    = (r_state == c_ISSUE) || (r_state == c_WAIT);
    rsp_vld     = (r_state == c_RSP);
    busy        = (r_state != c_IDLE);
  end

  // Query target and response data; response is held until the next count finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target       <= '0;
      r_rsp_quantity <= '0;
      r_rsp_ok       <= 1'b0;
    end else begin
      if (r_state == c_IDLE && req_vld) begin
        r_target <= req_quantity;
      end
      if (w_cnt_done) begin
        r_rsp_quantity <= cnt_rsp_quantity;
        r_rsp_ok       <= (cnt_rsp_quantity >= w_target_ext);
      end else if (w_timeout) begin
        r_rsp_quantity <= '0;
        r_rsp_ok       <= 1'b0;
      end
    end
  end

  assign rsp_quantity = r_rsp_quantity;
  assign rsp_ok       = r_rsp_ok;

endmodule
`default_nettype wire
